// File: rtl/conv_requant_fifo_if.sv
// Interface bundling the result input strobe and the downstream valid/ready
// drain port of conv_requant_fifo, plus its status outputs.
interface conv_requant_fifo_if #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 12,
  parameter int AW    = 3
);
  logic              in_valid;
  logic [IN_W-1:0]   in_data;
  logic              out_ready;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic [AW:0]       fifo_level;
  logic              sat_flag;
  logic              overflow;

  // Producer/consumer side: feeds results, accepts samples.
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, fifo_level, sat_flag, overflow
  );

  // Requantiser side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, fifo_level, sat_flag, overflow
  );
endinterface

// File: rtl/conv_requant_fifo.sv
// conv_requant_fifo: scales 24-bit signed convolution results by an
// arithmetic right shift, saturates them to 12 bits and buffers them in a
// DEPTH-entry FIFO drained over valid/ready.
// Build option: define CONV_REQ_ROUND_EN for round-half-up scaling;
// left undefined, scaling is plain truncation (floor).
module conv_requant_fifo #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 12,
  parameter int SHIFT = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               reset,
  conv_requant_fifo_if.slave bus
);
  // One guard bit so the rounding add cannot wrap.
  localparam int EW = IN_W + 1;

`ifdef CONV_REQ_ROUND_EN
  localparam logic signed [EW-1:0] RND = EW'(1 << (SHIFT - 1));
`else
  localparam logic signed [EW-1:0] RND = '0;
`endif

  localparam logic signed [EW-1:0] SAT_MAX = EW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [EW-1:0] SAT_MIN = EW'(-(2 ** (OUT_W - 1)));
  localparam logic [OUT_W-1:0]     OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0]     OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};
  localparam logic [AW:0]          LEVEL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]          LEVEL_ONE  = (AW + 1)'(1);

  // Stage 1/2 pipeline state
  logic signed [EW-1:0] s1_reg;
  logic                 v1_reg;
  logic [OUT_W-1:0]     s2_reg;
  logic                 v2_reg;
  logic                 sat_flag_reg;

  // FIFO state
  logic [OUT_W-1:0]     mem [DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [AW:0]          level_reg;
  logic [AW:0]          level_next;

  logic signed [EW-1:0] in_ext;
  logic signed [EW-1:0] scaled;
  logic                 sat_hi;
  logic                 sat_lo;
  logic [OUT_W-1:0]     clamped;
  logic                 full;
  logic                 pop;
  logic                 push;

  assign in_ext  = EW'($signed(bus.in_data));
  assign scaled  = (in_ext + RND) >>> SHIFT;

  assign sat_hi  = s1_reg > SAT_MAX;
  assign sat_lo  = s1_reg < SAT_MIN;
  assign clamped = sat_hi ? OUT_MAX : (sat_lo ? OUT_MIN : s1_reg[OUT_W-1:0]);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts a push.
  assign full = (level_reg == LEVEL_FULL);
  assign pop  = (level_reg != '0) && bus.out_ready;
  assign push = v2_reg && (!full || pop);

  assign bus.overflow   = v2_reg && full && !pop;
  assign bus.out_valid  = (level_reg != '0);
  assign bus.out_data   = mem[rd_ptr_reg];
  assign bus.fifo_level = level_reg;
  assign bus.sat_flag   = sat_flag_reg;

  // Data path registers; validity is tracked separately so these need no reset.
  always_ff @(posedge clk) begin
    s1_reg <= scaled;
    s2_reg <= clamped;
  end

  // Pipeline valids and the sticky saturation flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v1_reg       <= 1'b0;
      v2_reg       <= 1'b0;
      sat_flag_reg <= 1'b0;
    end else begin
      v1_reg <= bus.in_valid;
      v2_reg <= v1_reg;
      if (v1_reg && (sat_hi || sat_lo)) begin
        sat_flag_reg <= 1'b1;
      end
    end
  end

  // Occupancy: unchanged when push and pop coincide.
  always_comb begin
    level_next = level_reg;
    if (push && !pop) begin
      level_next = level_reg + LEVEL_ONE;
    end else if (pop && !push) begin
      level_next = level_reg - LEVEL_ONE;
    end
  end

  // Pointers and level; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      level_reg <= level_next;
    end
  end

  // Sample storage; contents are left alone during reset.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr_reg] <= s2_reg;
    end
  end
endmodule
